// File: rtl/cpu16_pkg.sv
// Shared constants for the 16-bit CPU datapath blocks.
package cpu16_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W_DEF = 8;

endpackage

// File: rtl/demux1in2_buf_out_slot.sv
// Single-entry output buffer with a valid/ready drain and a wrapping transfer counter.
module out_slot
  import cpu16_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] cnt
);

  logic drain;

  assign drain = valid && ready;

  // A load on the same edge as a drain keeps the slot full with the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
      cnt   <= '0;
    end else begin
      if (load) begin
        valid <= 1'b1;
        dout  <= din;
      end else if (drain) begin
        valid <= 1'b0;
      end
      if (drain) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/demux1in2_buf.sv
// Registered 1-to-2 demultiplexer: one valid/ready input steered by S into two buffered outputs.
module demux1in2_buf
  import cpu16_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Hyrja,
  input  logic             S,
  input  logic             hyrja_valid,
  output logic             hyrja_ready,
  output logic [WIDTH-1:0] Dalja0,
  output logic             dalja0_valid,
  input  logic             dalja0_ready,
  output logic [WIDTH-1:0] Dalja1,
  output logic             dalja1_valid,
  input  logic             dalja1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic accept;
  logic load0;
  logic load1;

  // Only the selected output's occupancy and ready gate the input.
  assign hyrja_ready = S ? (!dalja1_valid || dalja1_ready)
                         : (!dalja0_valid || dalja0_ready);
  assign accept      = hyrja_valid && hyrja_ready;
  assign load0       = accept && !S;
  assign load1       = accept && S;

  out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
    .clk   (clk),
    .rst   (rst),
    .load  (load0),
    .din   (Hyrja),
    .ready (dalja0_ready),
    .valid (dalja0_valid),
    .dout  (Dalja0),
    .cnt   (cnt0)
  );

  out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
    .clk   (clk),
    .rst   (rst),
    .load  (load1),
    .din   (Hyrja),
    .ready (dalja1_ready),
    .valid (dalja1_valid),
    .dout  (Dalja1),
    .cnt   (cnt1)
  );

endmodule

// File: doc/demux1in2_buf.md
# demux1in2_buf

Registered 1-to-2 demultiplexer for 16-bit datapath traffic: one valid/ready input stream is steered by select `S` into one of two single-entry output buffers, each drained independently by its own valid/ready consumer. It is the distributing counterpart of the 2-to-1 source mux in the CPU datapath. It routes one producer, such as the ALU result, to one of two sinks, such as register-file writeback and the output port. Per-output transfer counters support debug.

## Interface
Parameters:
- `WIDTH`, default 16: data width.
- `CNT_W`, default 8: width of each transfer counter.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `Hyrja`, in, WIDTH: input data.
- `S`, in, 1: destination select; 0 selects output 0, 1 selects output 1.
- `hyrja_valid`, in, 1: input word present.
- `hyrja_ready`, out, 1: block accepts the input this cycle.
- `Dalja0`, out, WIDTH: output 0 data (registered).
- `dalja0_valid`, out, 1: output 0 buffer full.
- `dalja0_ready`, in, 1: consumer 0 takes the word.
- `Dalja1`, out, WIDTH: output 1 data (registered).
- `dalja1_valid`, out, 1: output 1 buffer full.
- `dalja1_ready`, in, 1: consumer 1 takes the word.
- `cnt0`, out, CNT_W: count of completed output-0 handshakes.
- `cnt1`, out, CNT_W: count of completed output-1 handshakes.

## Operation
- State per output k: `full_k` (drives `daljak_valid`), data register `Daljak`, counter `cntk`.
- `hyrja_ready = !full_S || daljaS_ready`. This is combinational from `S` and the selected output's ready. The unselected output never affects it.
- Input accept: `hyrja_valid && hyrja_ready`. On the next edge, `Dalja_S <= Hyrja` and `full_S <= 1`.
- Output drain: `daljak_valid && daljak_ready` at an edge. Then `full_k <= 0`, unless a refill of output k happens on the same edge. `cntk` increments on every drain.
- Simultaneous drain and refill of the same output: `full_k` stays 1, new data is loaded, the counter increments. This gives full throughput of one word per cycle per output.
- Drain of one output while the other output is filled: both happen independently in the same cycle.
- `Daljak` is stable while `daljak_valid && !daljak_ready`. It loads only on accept. It holds its last value when empty.
- `S` may change freely while `hyrja_valid` is high and the input is not accepted. Routing uses `S` at the accepting edge only.
- Counters wrap: `2^CNT_W-1` goes to 0, with no saturation.
- Reset, including mid-operation: `full0 = full1 = 0`, `Dalja0 = Dalja1 = 0`, `cnt0 = cnt1 = 0`. Buffered words are discarded. `hyrja_ready` is 1 right after reset, because both buffers are empty.

## Timing
- Latency: a word accepted at edge N is visible with valid high on its output after edge N (one cycle).
- No combinational path from `Hyrja` to `Dalja*`.
- Combinational paths:
  - `S` to `hyrja_ready`.
  - `dalja*_ready` to `hyrja_ready`.
- The consumer must not make `dalja*_ready` depend on `hyrja_ready`.
- Input handshake rule: the producer holds `Hyrja` and `S` stable while `hyrja_valid && !hyrja_ready`. A bench assertion checks this; the block does not depend on it.
- Output handshake rule: once `daljak_valid` rises, it stays high with constant data until the handshake completes.

## Structure
- Shared package `cpu16_pkg`: `DATA_W = 16` constant, used as the `WIDTH` default.
- Sub-module `out_slot`, instantiated twice. It holds one full flag, the data register, and the counter. Its inputs are `load`, `din`, and `ready`. Its outputs are `valid`, `dout`, and `cnt`.
- Top level: select decode (`load_k = accept && (S == k)`) and the `hyrja_ready` mux.

## Test plan
- Reset, then `S=0`, `Hyrja=16'h1234`, valid for one cycle. Expect `dalja0_valid=1` and `Dalja0=16'h1234` after one edge. Output 1 stays invalid. `cnt0` goes to 1 after `dalja0_ready` is pulsed.
- Output 0 stalled (`dalja0_ready=0`) and full; send `S=0`, `16'hAAAA`. Expect `hyrja_ready=0` and `Dalja0` held at the old value. Switch to `S=1`: `hyrja_ready=1`, and `16'hAAAA` lands in `Dalja1`.
- `dalja0_ready=1` held constantly; stream `16'h0001..16'h0008` with `S=0` on 8 consecutive cycles. Expect `hyrja_ready` to be 1 throughout, 8 words out in order with one-cycle latency, and `cnt0=8`.
- Same cycle: drain output 1 and accept `S=0`, `16'hBEEF`. Expect `dalja1_valid=0`, `Dalja0=16'hBEEF`, and `cnt1` incremented.
- Force 256 drains on output 0 (`CNT_W=8`). Expect `cnt0` to go from 255 to 0.
- Both outputs full, assert `rst` for one cycle. Expect all valids 0, `Dalja0=Dalja1=0`, counters 0, and `hyrja_ready=1` on the next cycle.
